video_mode_sequencer: RTL

VIDEO_MODE_SEQUENCER -- requirements
Module: video_mode_sequencer

---
 rtl/video_mode_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/video_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : video_mode_sequencer
// Description : Selects the active test pattern for an RGB generator.
//               Handles manual mode changes over a four-phase req/ack
//               handshake and applies them only at frame boundaries.
//               Detects frame starts from vsync and keeps a free-running
//               16-bit frame counter.
//               Optional auto-cycle is enabled by defining the macro
//               VIDEO_MODE_SEQ_AUTO_EN. It steps the pattern once every
//               FRAMES_PER_STEP frames while idle.
// Revision    : 1.0 - initial release
// ============================================================================
module video_mode_sequencer #(
    parameter int NUM_MODES       = 6,
    parameter int FRAMES_PER_STEP = 60
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        vsync_i,
    input  logic        req_i,
    input  logic [2:0]  mode_i,
    input  logic        auto_i,
    output logic        ack_o,
    output logic [2:0]  pattern_o,
    output logic        frame_start_o,
    output logic [15:0] frame_cnt_o
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_PENDING = 2'd1;
    localparam logic [1:0] c_ST_ACK     = 2'd2;

    localparam logic [3:0] c_NUM_MODES  = 4'(NUM_MODES);
    localparam logic [2:0] c_MODE_LAST  = 3'(NUM_MODES - 1);

    logic [1:0] r_state;
    logic       r_vsync_d;
    logic [2:0] r_mode;
    logic [2:0] w_mode_clamped;

    // Out-of-range requests select the highest legal mode.
    assign w_mode_clamped = ({1'b0, mode_i} >= c_NUM_MODES) ? c_MODE_LAST : mode_i;

`ifdef VIDEO_MODE_SEQ_AUTO_EN
    localparam logic [15:0] c_STEP_LAST = 16'(FRAMES_PER_STEP - 1);

    logic [15:0] r_step;
    logic [2:0]  w_pattern_next;

    // Next pattern in the auto-cycle, wrapping after the last mode.
    assign w_pattern_next = (pattern_o == c_MODE_LAST) ? 3'd0 : pattern_o + 3'd1;
`else
    // Auto-cycle is compiled out, so the enable input has no effect.
    logic w_unused_auto;
    assign w_unused_auto = auto_i;
`endif

    // Rising-edge detect on vsync gives a one-cycle frame_start pulse; the counter counts those pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vsync_d     <= 1'b0;
            frame_start_o <= 1'b0;
            frame_cnt_o   <= 16'd0;
        end else begin
            r_vsync_d     <= vsync_i;
            frame_start_o <= vsync_i & ~r_vsync_d;
            if (frame_start_o) begin
                frame_cnt_o <= frame_cnt_o + 16'd1;
            end
        end
    end

    // Request handshake FSM; pattern changes only on a frame_start cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= c_ST_IDLE;
            r_mode    <= 3'd0;
            pattern_o <= 3'd0;
            ack_o     <= 1'b0;
`ifdef VIDEO_MODE_SEQ_AUTO_EN
            r_step    <= 16'd0;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (req_i) begin
                        // Capture happens even on a frame_start cycle.
                        // The new mode then waits for the next frame.
                        r_mode  <= w_mode_clamped;
                        r_state <= c_ST_PENDING;
                    end
`ifdef VIDEO_MODE_SEQ_AUTO_EN
                    else if (auto_i && frame_start_o) begin
                        if (r_step == c_STEP_LAST) begin
                            pattern_o <= w_pattern_next;
                            r_step    <= 16'd0;
                        end else begin
                            r_step <= r_step + 16'd1;
                        end
                    end
`endif
                end
                c_ST_PENDING: begin
                    // Dropping req here does not cancel the request. It is still applied at the frame boundary.
                    if (frame_start_o) begin
                        pattern_o <= r_mode;
                        ack_o     <= 1'b1;
                        r_state   <= c_ST_ACK;
`ifdef VIDEO_MODE_SEQ_AUTO_EN
                        r_step    <= 16'd0;
`endif
                    end
                end
                c_ST_ACK: begin
                    if (!req_i) begin
                        ack_o   <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    ack_o   <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
`ifdef VIDEO_MODE_SEQ_AUTO_EN
            // With auto-cycle off, the step count always starts again from zero.
            if (!auto_i) begin
                r_step <= 16'd0;
            end
`endif
        end
    end

endmodule
`default_nettype wire
